// File: rtl/spi_slave_core_if.sv
// Pin-side and user-side signals of the SPI slave core.
// slave modport is the core's view; master modport is the view of whoever drives it.
interface spi_slave_core_if #(
   parameter int WIDTH = 8
);
   logic             CS_i;
   logic             SCK_i;
   logic             MOSI_i;
   logic             MISO_o;
   logic             MISO_OE_o;
   logic [WIDTH-1:0] TxData_i;
   logic             TxValid_i;
   logic             TxReady_o;
   logic [WIDTH-1:0] RxData_o;
   logic             RxValid_o;
   logic             Busy_o;
   logic             Underrun_o;
   logic             FrameAbort_o;

   modport slave (
      input  CS_i, SCK_i, MOSI_i, TxData_i, TxValid_i,
      output MISO_o, MISO_OE_o, TxReady_o, RxData_o, RxValid_o,
             Busy_o, Underrun_o, FrameAbort_o
   );

   modport master (
      output CS_i, SCK_i, MOSI_i, TxData_i, TxValid_i,
      input  MISO_o, MISO_OE_o, TxReady_o, RxData_o, RxValid_o,
             Busy_o, Underrun_o, FrameAbort_o
   );
endinterface

// File: rtl/spi_slave_core.sv
// Full-duplex SPI slave, any CPOL/CPHA, oversampled in the Clock domain.
// TX words come from a one-entry holding register; RX words leave as a one-cycle strobe.
module spi_slave_core #(
   parameter int WIDTH       = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             Clock,
   input  logic             Reset,
   spi_slave_core_if.slave  bus
);
   localparam int   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   cs_prev_q, cs_prev_d;
   logic                   sck_prev_q, sck_prev_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]       rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0]       tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0]       hold_q, hold_d;
   logic [WIDTH-1:0]       rx_data_q, rx_data_d;
   logic                   hold_vld_q, hold_vld_d;
   logic                   word_done_q, word_done_d;
   logic                   rx_vld_q, rx_vld_d;
   logic                   busy_q, busy_d;
   logic                   underrun_q, underrun_d;
   logic                   abort_q, abort_d;

   logic cs_s, sck_s, mosi_s;
   logic cs_fall, cs_rise, sck_rise, sck_fall;
   logic lead_edge, trail_edge, sample_edge, shift_edge, load_evt;
   logic [WIDTH-1:0] rx_new;

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // SCK edges are only meaningful inside a frame.
   assign cs_fall    = cs_prev_q & ~cs_s;
   assign cs_rise    = ~cs_prev_q & cs_s;
   assign sck_rise   = ~sck_prev_q & sck_s & ~cs_s;
   assign sck_fall   = sck_prev_q & ~sck_s & ~cs_s;
   assign lead_edge  = (SCK_IDLE == 1'b1) ? sck_fall : sck_rise;
   assign trail_edge = (SCK_IDLE == 1'b1) ? sck_rise : sck_fall;
   assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
   assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

   // CPHA=0 must present bit 0 before the first sample edge, hence the load at CS fall.
   assign load_evt = (CPHA != 0) ? (shift_edge && (cnt_q == '0))
                                 : (cs_fall || (shift_edge && word_done_q));

   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.CS_i};
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK_i};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI_i};
      cs_prev_d   = cs_s;
      sck_prev_d  = sck_s;
      cnt_d       = cnt_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      rx_data_d   = rx_data_q;
      word_done_d = word_done_q;
      rx_vld_d    = 1'b0;
      underrun_d  = 1'b0;
      abort_d     = 1'b0;
      busy_d      = ~cs_s;
      rx_new      = (MSB_FIRST != 0) ? {rx_sh_q[WIDTH-2:0], mosi_s}
                                     : {mosi_s, rx_sh_q[WIDTH-1:1]};

      if (load_evt) begin
         tx_sh_d     = hold_vld_q ? hold_q : '0;
         underrun_d  = ~hold_vld_q;
         hold_vld_d  = 1'b0;
         word_done_d = 1'b0;
      end else if (shift_edge) begin
         tx_sh_d = (MSB_FIRST != 0) ? {tx_sh_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, tx_sh_q[WIDTH-1:1]};
      end

      // Acceptance looks at the registered hold state: no bypass into a same-cycle load.
      if (bus.TxValid_i && !hold_vld_q) begin
         hold_d     = bus.TxData_i;
         hold_vld_d = 1'b1;
      end

      if (cs_fall) begin
         cnt_d       = '0;
         rx_sh_d     = '0;
         word_done_d = 1'b0;
      end else if (cs_rise) begin
         abort_d     = (cnt_q != '0);
         cnt_d       = '0;
         rx_sh_d     = '0;
         word_done_d = 1'b0;
      end else if (sample_edge) begin
         rx_sh_d = rx_new;
         if (cnt_q == CW'(WIDTH - 1)) begin
            rx_data_d   = rx_new;
            rx_vld_d    = 1'b1;
            cnt_d       = '0;
            word_done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b1;
         sck_prev_q  <= SCK_IDLE;
         cnt_q       <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
         rx_data_q   <= '0;
         word_done_q <= 1'b0;
         rx_vld_q    <= 1'b0;
         busy_q      <= 1'b0;
         underrun_q  <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_prev_q   <= cs_prev_d;
         sck_prev_q  <= sck_prev_d;
         cnt_q       <= cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         rx_data_q   <= rx_data_d;
         word_done_q <= word_done_d;
         rx_vld_q    <= rx_vld_d;
         busy_q      <= busy_d;
         underrun_q  <= underrun_d;
         abort_q     <= abort_d;
      end
   end

   assign bus.MISO_o       = ~cs_s & ((MSB_FIRST != 0) ? tx_sh_q[WIDTH-1] : tx_sh_q[0]);
   assign bus.MISO_OE_o    = ~cs_s;
   assign bus.TxReady_o    = ~hold_vld_q;
   assign bus.RxData_o     = rx_data_q;
   assign bus.RxValid_o    = rx_vld_q;
   assign bus.Busy_o       = busy_q;
   assign bus.Underrun_o   = underrun_q;
   assign bus.FrameAbort_o = abort_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: four WIDTH=8 cores (modes 0..3) and one WIDTH=16 LSB-first core.
// A behavioural SPI master per core drives pins and reassembles MISO.
module tb_spi_slave_core;
   localparam int HP = 8;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   logic        cs_n [5];
   logic        sck  [5];
   logic        mosi [5];
   logic [31:0] txd  [5];
   logic        txv  [5];
   logic        miso [5];
   logic        oe   [5];
   logic        txr  [5];
   logic [31:0] rxd  [5];
   logic        rxv  [5];
   logic        busy [5];
   logic        und  [5];
   logic        abt  [5];

   int vectors = 0;
   int miscompares = 0;
   int rxv_n [5] = '{default: 0};
   int und_n [5] = '{default: 0};
   int abt_n [5] = '{default: 0};

   spi_slave_core_if #(.WIDTH(8))  if0 ();
   spi_slave_core_if #(.WIDTH(8))  if1 ();
   spi_slave_core_if #(.WIDTH(8))  if2 ();
   spi_slave_core_if #(.WIDTH(8))  if3 ();
   spi_slave_core_if #(.WIDTH(16)) if4 ();

   spi_slave_core #(.WIDTH(8),  .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2))
      u0 (.Clock(Clock), .Reset(Reset), .bus(if0));
   spi_slave_core #(.WIDTH(8),  .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2))
      u1 (.Clock(Clock), .Reset(Reset), .bus(if1));
   spi_slave_core #(.WIDTH(8),  .CPOL(1), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2))
      u2 (.Clock(Clock), .Reset(Reset), .bus(if2));
   spi_slave_core #(.WIDTH(8),  .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2))
      u3 (.Clock(Clock), .Reset(Reset), .bus(if3));
   spi_slave_core #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2))
      u4 (.Clock(Clock), .Reset(Reset), .bus(if4));

   assign if0.CS_i = cs_n[0]; assign if0.SCK_i = sck[0]; assign if0.MOSI_i = mosi[0];
   assign if0.TxData_i = txd[0][7:0]; assign if0.TxValid_i = txv[0];
   assign miso[0] = if0.MISO_o; assign oe[0] = if0.MISO_OE_o; assign txr[0] = if0.TxReady_o;
   assign rxd[0] = {24'd0, if0.RxData_o}; assign rxv[0] = if0.RxValid_o; assign busy[0] = if0.Busy_o;
   assign und[0] = if0.Underrun_o; assign abt[0] = if0.FrameAbort_o;

   assign if1.CS_i = cs_n[1]; assign if1.SCK_i = sck[1]; assign if1.MOSI_i = mosi[1];
   assign if1.TxData_i = txd[1][7:0]; assign if1.TxValid_i = txv[1];
   assign miso[1] = if1.MISO_o; assign oe[1] = if1.MISO_OE_o; assign txr[1] = if1.TxReady_o;
   assign rxd[1] = {24'd0, if1.RxData_o}; assign rxv[1] = if1.RxValid_o; assign busy[1] = if1.Busy_o;
   assign und[1] = if1.Underrun_o; assign abt[1] = if1.FrameAbort_o;

   assign if2.CS_i = cs_n[2]; assign if2.SCK_i = sck[2]; assign if2.MOSI_i = mosi[2];
   assign if2.TxData_i = txd[2][7:0]; assign if2.TxValid_i = txv[2];
   assign miso[2] = if2.MISO_o; assign oe[2] = if2.MISO_OE_o; assign txr[2] = if2.TxReady_o;
   assign rxd[2] = {24'd0, if2.RxData_o}; assign rxv[2] = if2.RxValid_o; assign busy[2] = if2.Busy_o;
   assign und[2] = if2.Underrun_o; assign abt[2] = if2.FrameAbort_o;

   assign if3.CS_i = cs_n[3]; assign if3.SCK_i = sck[3]; assign if3.MOSI_i = mosi[3];
   assign if3.TxData_i = txd[3][7:0]; assign if3.TxValid_i = txv[3];
   assign miso[3] = if3.MISO_o; assign oe[3] = if3.MISO_OE_o; assign txr[3] = if3.TxReady_o;
   assign rxd[3] = {24'd0, if3.RxData_o}; assign rxv[3] = if3.RxValid_o; assign busy[3] = if3.Busy_o;
   assign und[3] = if3.Underrun_o; assign abt[3] = if3.FrameAbort_o;

   assign if4.CS_i = cs_n[4]; assign if4.SCK_i = sck[4]; assign if4.MOSI_i = mosi[4];
   assign if4.TxData_i = txd[4][15:0]; assign if4.TxValid_i = txv[4];
   assign miso[4] = if4.MISO_o; assign oe[4] = if4.MISO_OE_o; assign txr[4] = if4.TxReady_o;
   assign rxd[4] = {16'd0, if4.RxData_o}; assign rxv[4] = if4.RxValid_o; assign busy[4] = if4.Busy_o;
   assign und[4] = if4.Underrun_o; assign abt[4] = if4.FrameAbort_o;

   always @(posedge Clock) begin
      for (int k = 0; k < 5; k++) begin
         if (rxv[k]) rxv_n[k] <= rxv_n[k] + 1;
         if (und[k]) und_n[k] <= und_n[k] + 1;
         if (abt[k]) abt_n[k] <= abt_n[k] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic push_tx(input int d, input logic [31:0] w);
      txd[d] = w;
      txv[d] = 1'b1;
      wait_clk(1);
      txv[d] = 1'b0;
   endtask

   task automatic cs_low(input int d);
      cs_n[d] = 1'b0;
      wait_clk(HP);
   endtask

   task automatic cs_high(input int d);
      wait_clk(HP);
      cs_n[d] = 1'b1;
      wait_clk(2 * HP);
   endtask

   // Master side of one word: drives MOSI, toggles SCK, samples MISO on the sample edge.
   task automatic xfer(input int d, input int nbits, input logic [31:0] w, output logic [31:0] m);
      bit cpol, cpha, msb;
      int width, b;
      cpol  = (d == 2 || d == 3);
      cpha  = (d == 1 || d == 3);
      msb   = (d != 4);
      width = (d == 4) ? 16 : 8;
      m = '0;
      for (int i = 0; i < nbits; i++) begin
         b = msb ? (width - 1 - i) : i;
         if (!cpha) begin
            mosi[d] = w[b];
            wait_clk(HP);
            sck[d]  = ~cpol;
            m[b]    = miso[d];
            wait_clk(HP);
            sck[d]  = cpol;
         end else begin
            sck[d]  = ~cpol;
            mosi[d] = w[b];
            wait_clk(HP);
            sck[d]  = cpol;
            m[b]    = miso[d];
            wait_clk(HP);
         end
      end
   endtask

   initial begin
      logic [31:0] m1, m2;
      int rb, ub, ab;
      for (int k = 0; k < 5; k++) begin
         cs_n[k] = 1'b1;
         sck[k]  = (k == 2 || k == 3);
         mosi[k] = 1'b0;
         txd[k]  = '0;
         txv[k]  = 1'b0;
      end

      // Reset state
      wait_clk(3);
      chk("rst_miso", {31'd0, miso[0]}, 32'd0);
      chk("rst_oe", {31'd0, oe[0]}, 32'd0);
      chk("rst_txready", {31'd0, txr[0]}, 32'd1);
      chk("rst_rxdata", rxd[0], 32'd0);
      chk("rst_flags", {28'd0, rxv[0], busy[0], und[0], abt[0]}, 32'd0);
      Reset = 1'b1;
      wait_clk(4);

      // Single word in every mode: hold 0xA5, master sends 0x3C
      for (int d = 0; d < 4; d++) begin
         rb = rxv_n[d];
         push_tx(d, 32'hA5);
         chk("m_txready_full", {31'd0, txr[d]}, 32'd0);
         cs_low(d);
         chk("m_txready_csfall", {31'd0, txr[d]}, (d == 0 || d == 2) ? 32'd1 : 32'd0);
         chk("m_busy_oe", {30'd0, busy[d], oe[d]}, 32'd3);
         xfer(d, 8, 32'h3C, m1);
         cs_high(d);
         chk("m_miso", m1, 32'hA5);
         chk("m_rxdata", rxd[d], 32'h3C);
         chk("m_rxvalid_cnt", rxv_n[d] - rb, 32'd1);
         chk("m_busy_off", {31'd0, busy[d]}, 32'd0);
      end

      // Back-to-back words in one frame (mode 1)
      rb = rxv_n[1]; ub = und_n[1];
      push_tx(1, 32'hA5);
      cs_low(1);
      xfer(1, 8, 32'h11, m1);
      chk("b2b_rx1", rxd[1], 32'h11);
      push_tx(1, 32'h5A);
      xfer(1, 8, 32'h22, m2);
      cs_high(1);
      chk("b2b_miso1", m1, 32'hA5);
      chk("b2b_miso2", m2, 32'h5A);
      chk("b2b_rx2", rxd[1], 32'h22);
      chk("b2b_rxvalid_cnt", rxv_n[1] - rb, 32'd2);
      chk("b2b_underrun_cnt", und_n[1] - ub, 32'd0);

      // Underrun: nothing loaded
      ub = und_n[1];
      chk("ur_txready", {31'd0, txr[1]}, 32'd1);
      cs_low(1);
      xfer(1, 8, 32'hFF, m1);
      cs_high(1);
      chk("ur_miso", m1, 32'h00);
      chk("ur_underrun_cnt", und_n[1] - ub, 32'd1);
      chk("ur_rxdata", rxd[1], 32'hFF);

      // Aborted frame after 5 bits, then a clean frame
      rb = rxv_n[1]; ab = abt_n[1];
      cs_low(1);
      xfer(1, 5, 32'hFF, m1);
      cs_high(1);
      chk("ab_abort_cnt", abt_n[1] - ab, 32'd1);
      chk("ab_rxvalid_cnt", rxv_n[1] - rb, 32'd0);
      chk("ab_rxdata_kept", rxd[1], 32'hFF);
      cs_low(1);
      xfer(1, 8, 32'h81, m1);
      cs_high(1);
      chk("ab_next_rx", rxd[1], 32'h81);
      chk("ab_next_rxvalid", rxv_n[1] - rb, 32'd1);
      chk("ab_next_abort", abt_n[1] - ab, 32'd1);

      // WIDTH=16, LSB first: full frame, then reset mid-frame, then clean frame
      push_tx(4, 32'h1357);
      cs_low(4);
      xfer(4, 16, 32'hBEEF, m1);
      cs_high(4);
      chk("w16_miso", m1, 32'h1357);
      chk("w16_rx", rxd[4], 32'hBEEF);
      push_tx(4, 32'h00FF);
      cs_low(4);
      xfer(4, 6, 32'hFFFF, m1);
      Reset = 1'b0;
      wait_clk(1);
      chk("rst_mid_miso_oe", {30'd0, miso[4], oe[4]}, 32'd0);
      chk("rst_mid_txready", {31'd0, txr[4]}, 32'd1);
      chk("rst_mid_rxdata", rxd[4], 32'd0);
      chk("rst_mid_flags", {28'd0, rxv[4], busy[4], und[4], abt[4]}, 32'd0);
      cs_n[4] = 1'b1;
      wait_clk(4);
      Reset = 1'b1;
      wait_clk(4);
      rb = rxv_n[4]; ab = abt_n[4];
      push_tx(4, 32'hC3A5);
      cs_low(4);
      xfer(4, 16, 32'h1234, m1);
      cs_high(4);
      chk("w16_post_rx", rxd[4], 32'h1234);
      chk("w16_post_miso", m1, 32'hC3A5);
      chk("w16_post_rxvalid", rxv_n[4] - rb, 32'd1);
      chk("w16_post_abort", abt_n[4] - ab, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
